// File: rtl/fifo_serial_tx_if.sv
// Handshake bundle between the byte fifo read port and the serial transmitter.
// The transmitter takes the slave side; the fifo/driver side takes master.
interface fifo_serial_tx_if #(
   parameter int DATA_W = 8
);
   logic              tx_en;
   logic              fifo_empty;
   logic [DATA_W-1:0] out_d;
   logic              read_flg;
   logic              tx_line;
   logic              busy;
   logic              byte_done;

   modport master (
      output tx_en, fifo_empty, out_d,
      input  read_flg, tx_line, busy, byte_done
   );

   modport slave (
      input  tx_en, fifo_empty, out_d,
      output read_flg, tx_line, busy, byte_done
   );
endinterface

// File: rtl/fifo_serial_tx.sv
// Drains the fifo one word at a time and sends each word as an async serial
// frame: one start bit, DATA_W data bits LSB first, STOP_BITS stop bits.
module fifo_serial_tx #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int STOP_BITS    = 1,
   parameter int RD_LAT       = 1
) (
   input  logic             out_clk,
   input  logic             reset,
   fifo_serial_tx_if.slave  bus
);
   localparam int STOP_LEN = STOP_BITS * CLKS_PER_BIT;
   localparam int CNT_W    = $clog2(STOP_LEN + CLKS_PER_BIT + RD_LAT + 2);
   localparam int BIT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_LEN - 1);
   localparam logic [CNT_W-1:0] STOP_PRE  = CNT_W'(STOP_LEN - 2);
   localparam logic [CNT_W-1:0] WAIT_CAP  = CNT_W'(RD_LAT - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RD_LAT);
   localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_POP   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_START = 3'd3,
      ST_DATA  = 3'd4,
      ST_STOP  = 3'd5
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] shreg_next;
   logic              pop_req;

   assign pop_req    = bus.tx_en & ~bus.fifo_empty;
   assign shreg_next = shreg >> 1;

   // Frame sequencer; outputs are set one edge ahead so they appear registered
   // in the same cycle the state describes.
   always_ff @(posedge out_clk or posedge reset) begin
      if (reset) begin
         state         <= ST_IDLE;
         cnt           <= '0;
         bit_cnt       <= '0;
         shreg         <= '0;
         bus.read_flg  <= 1'b0;
         bus.tx_line   <= 1'b1;
         bus.busy      <= 1'b0;
         bus.byte_done <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               bus.tx_line   <= 1'b1;
               bus.byte_done <= 1'b0;
               cnt           <= '0;
               if (pop_req) begin
                  state        <= ST_POP;
                  bus.read_flg <= 1'b1;
                  bus.busy     <= 1'b1;
               end else begin
                  state        <= ST_IDLE;
                  bus.read_flg <= 1'b0;
                  bus.busy     <= 1'b0;
               end
            end
            ST_POP: begin
               bus.read_flg <= 1'b0;
               cnt          <= '0;
               state        <= ST_WAIT;
            end
            ST_WAIT: begin
               // Capture lands RD_LAT edges after the pop; the start bit goes
               // out one edge later, giving the RD_LAT+2 idle gap.
               if (cnt == WAIT_CAP) begin
                  shreg <= bus.out_d;
               end
               if (cnt == WAIT_LAST) begin
                  state       <= ST_START;
                  bus.tx_line <= 1'b0;
                  cnt         <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_START: begin
               if (cnt == BIT_LAST) begin
                  state       <= ST_DATA;
                  bus.tx_line <= shreg[0];
                  bit_cnt     <= '0;
                  cnt         <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt <= '0;
                  if (bit_cnt == DATA_LAST) begin
                     state         <= ST_STOP;
                     bus.tx_line   <= 1'b1;
                     bit_cnt       <= '0;
                     bus.byte_done <= (STOP_LEN == 1);
                  end else begin
                     bit_cnt     <= bit_cnt + BIT_W'(1);
                     shreg       <= shreg_next;
                     bus.tx_line <= shreg_next[0];
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_STOP: begin
               bus.tx_line <= 1'b1;
               if (cnt == STOP_LAST) begin
                  // Last stop cycle doubles as the next pop decision point.
                  bus.byte_done <= 1'b0;
                  cnt           <= '0;
                  if (pop_req) begin
                     state        <= ST_POP;
                     bus.read_flg <= 1'b1;
                     bus.busy     <= 1'b1;
                  end else begin
                     state    <= ST_IDLE;
                     bus.busy <= 1'b0;
                  end
               end else begin
                  cnt           <= cnt + CNT_W'(1);
                  bus.byte_done <= (STOP_LEN > 1) && (cnt == STOP_PRE);
               end
            end
            default: begin
               state         <= ST_IDLE;
               cnt           <= '0;
               bit_cnt       <= '0;
               bus.read_flg  <= 1'b0;
               bus.tx_line   <= 1'b1;
               bus.busy      <= 1'b0;
               bus.byte_done <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_fifo_serial_tx.sv
// Randomized bench for fifo_serial_tx: a queue-based fifo model feeds the DUT and
// captured per-cycle outputs are compared with a waveform built from frame rules.
module tb_fifo_serial_tx;
   localparam int DW     = 8;
   localparam int CPB    = 4;
   localparam int SB     = 1;
   localparam int RL     = 1;
   localparam int NBITS  = 1 + DW + SB;
   localparam int FRAME  = NBITS * CPB;
   localparam int PERIOD = FRAME + RL + 2;

   logic out_clk = 1'b0;
   logic reset   = 1'b1;

   fifo_serial_tx_if #(.DATA_W(DW)) bus();

   fifo_serial_tx #(
      .DATA_W(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(SB), .RD_LAT(RL)
   ) dut (
      .out_clk(out_clk),
      .reset  (reset),
      .bus    (bus)
   );

   always #5 out_clk = ~out_clk;

   // fifo model: one-cycle read latency, empty flag refreshed each falling edge
   logic [7:0] fq[$];
   int         underflow = 0;
   always @(posedge out_clk) begin
      if (bus.read_flg === 1'b1) begin
         if (fq.size() > 0) bus.out_d <= fq.pop_front();
         else underflow <= underflow + 1;
      end
   end
   always @(negedge out_clk) bus.fifo_empty <= (fq.size() == 0);

   int         pass_cnt  = 0;
   int         total_cnt = 0;
   logic [7:0] wq[$];
   logic [3:0] cap[$];
   logic [3:0] expq[$];
   logic [7:0] dec[$];

   // sample {tx_line, read_flg, busy, byte_done} on each falling edge
   task automatic capture(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge out_clk);
         cap.push_back({bus.tx_line, bus.read_flg, bus.busy, bus.byte_done});
      end
   endtask

   // expected waveform: each word occupies PERIOD cycles from its pop decision
   function automatic void build_exp(input int n);
      int         b, idx;
      logic       v;
      logic [7:0] w;
      logic [3:0] t;
      expq.delete();
      for (int i = 0; i < n; i++) expq.push_back(4'b1000);
      for (int k = 0; k < wq.size(); k++) begin
         b = k * PERIOD;
         w = wq[k];
         for (int c = 0; c < PERIOD; c++) begin
            if (b + c < n) begin
               t = expq[b + c];
               t[1] = 1'b1;
               if (c == 0) t[2] = 1'b1;
               if (c == PERIOD - 1) t[0] = 1'b1;
               expq[b + c] = t;
            end
         end
         for (int j = 0; j < NBITS; j++) begin
            v = (j == 0) ? 1'b0 : ((j <= DW) ? w[j-1] : 1'b1);
            for (int c = 0; c < CPB; c++) begin
               idx = b + RL + 2 + j * CPB + c;
               if (idx < n) begin
                  t = expq[idx];
                  t[3] = v;
                  expq[idx] = t;
               end
            end
         end
      end
   endfunction

   // UART-style decode of the captured line, sampling mid-bit
   function automatic void decode_line();
      int         i, idx;
      logic [7:0] v;
      logic [3:0] s;
      dec.delete();
      i = 1;
      while (i < cap.size()) begin
         if (cap[i][3] == 1'b0 && cap[i-1][3] == 1'b1) begin
            v = 8'h00;
            for (int bb = 0; bb < DW; bb++) begin
               idx = i + CPB * (1 + bb) + CPB / 2;
               if (idx < cap.size()) begin
                  s = cap[idx];
                  v[bb] = s[3];
               end
            end
            dec.push_back(v);
            i = i + FRAME;
         end else begin
            i = i + 1;
         end
      end
   endfunction

   function automatic int first_diff();
      for (int i = 0; i < expq.size(); i++) begin
         if (i >= cap.size()) return i;
         if (cap[i] !== expq[i]) return i;
      end
      return -1;
   endfunction

   function automatic int dec_diff();
      if (dec.size() != wq.size()) return 999;
      for (int i = 0; i < wq.size(); i++) if (dec[i] !== wq[i]) return i;
      return -1;
   endfunction

   function automatic int count_rf();
      int n = 0;
      for (int i = 0; i < cap.size(); i++) if (cap[i][2] == 1'b1) n++;
      return n;
   endfunction

   task automatic start_words();
      @(posedge out_clk);
      #1;
      for (int i = 0; i < wq.size(); i++) fq.push_back(wq[i]);
      @(negedge out_clk);
      bus.tx_en = 1'b1;
      cap.delete();
   endtask

   task automatic test_reset();
      logic [3:0] s;
      reset = 1'b1;
      bus.tx_en = 1'b0;
      repeat (3) @(negedge out_clk);
      s = {bus.tx_line, bus.read_flg, bus.busy, bus.byte_done};
      total_cnt++;
      if (s !== 4'b1000) $display("FAIL reset_state got %b want 1000", s);
      else pass_cnt++;
   endtask

   task automatic test_idle_disabled();
      int d;
      @(posedge out_clk);
      #1;
      fq.push_back(8'h5A);
      @(negedge out_clk);
      reset = 1'b0;
      cap.delete();
      capture(20);
      wq.delete();
      build_exp(20);
      d = first_diff();
      total_cnt++;
      if (d >= 0) $display("FAIL disabled_wave cycle %0d got %b want %b", d, cap[d], expq[d]);
      else pass_cnt++;
      total_cnt++;
      if (fq.size() != 1) $display("FAIL disabled_fifo got %0d words want 1", fq.size());
      else pass_cnt++;
      fq.delete();
      @(negedge out_clk);
   endtask

   task automatic test_single();
      int d;
      wq.delete();
      wq.push_back(8'hA5);
      start_words();
      capture(PERIOD + 17);
      build_exp(PERIOD + 17);
      d = first_diff();
      total_cnt++;
      if (d >= 0) $display("FAIL single_wave cycle %0d got %b want %b", d, cap[d], expq[d]);
      else pass_cnt++;
      decode_line();
      d = dec_diff();
      total_cnt++;
      if (d >= 0) $display("FAIL single_decode got %0d bytes want %0d (idx %0d)", dec.size(), wq.size(), d);
      else pass_cnt++;
      total_cnt++;
      if (count_rf() != 1) $display("FAIL single_pops got %0d want 1", count_rf());
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int d;
      wq.delete();
      for (int i = 0; i < 4; i++) wq.push_back(8'(i));
      start_words();
      capture(4 * PERIOD + 10);
      build_exp(4 * PERIOD + 10);
      d = first_diff();
      total_cnt++;
      if (d >= 0) $display("FAIL b2b_wave cycle %0d got %b want %b", d, cap[d], expq[d]);
      else pass_cnt++;
      decode_line();
      d = dec_diff();
      total_cnt++;
      if (d >= 0) $display("FAIL b2b_decode got %0d bytes want %0d (idx %0d)", dec.size(), wq.size(), d);
      else pass_cnt++;
      total_cnt++;
      if (count_rf() != 4) $display("FAIL b2b_pops got %0d want 4", count_rf());
      else pass_cnt++;
   endtask

   task automatic test_empty();
      int d;
      bus.tx_en = 1'b1;
      wq.delete();
      cap.delete();
      capture(50);
      build_exp(50);
      d = first_diff();
      total_cnt++;
      if (d >= 0) $display("FAIL empty_wave cycle %0d got %b want %b", d, cap[d], expq[d]);
      else pass_cnt++;
   endtask

   task automatic test_en_drop();
      int d;
      @(posedge out_clk);
      #1;
      fq.push_back(8'h3C);
      fq.push_back(8'h55);
      fq.push_back(8'h66);
      @(negedge out_clk);
      bus.tx_en = 1'b1;
      cap.delete();
      capture(RL + 2 + 3 * CPB + 2);
      bus.tx_en = 1'b0;
      capture(PERIOD + 30 - (RL + 2 + 3 * CPB + 2));
      wq.delete();
      wq.push_back(8'h3C);
      build_exp(PERIOD + 30);
      d = first_diff();
      total_cnt++;
      if (d >= 0) $display("FAIL endrop_wave cycle %0d got %b want %b", d, cap[d], expq[d]);
      else pass_cnt++;
      total_cnt++;
      if (fq.size() != 2) $display("FAIL endrop_fifo got %0d words want 2", fq.size());
      else pass_cnt++;
      fq.delete();
      @(negedge out_clk);
   endtask

   task automatic test_reset_mid();
      int d;
      @(posedge out_clk);
      #1;
      fq.push_back(8'h81);
      fq.push_back(8'hC3);
      @(negedge out_clk);
      bus.tx_en = 1'b1;
      cap.delete();
      capture(RL + 2 + 6 * CPB + 2);
      reset = 1'b1;
      #1;
      total_cnt++;
      if ({bus.tx_line, bus.busy, bus.read_flg} !== 3'b100)
         $display("FAIL midreset_immediate got %b want 100", {bus.tx_line, bus.busy, bus.read_flg});
      else pass_cnt++;
      @(negedge out_clk);
      @(negedge out_clk);
      reset = 1'b0;
      cap.delete();
      capture(PERIOD + 17);
      wq.delete();
      wq.push_back(8'hC3);
      build_exp(PERIOD + 17);
      d = first_diff();
      total_cnt++;
      if (d >= 0) $display("FAIL midreset_wave cycle %0d got %b want %b", d, cap[d], expq[d]);
      else pass_cnt++;
      decode_line();
      d = dec_diff();
      total_cnt++;
      if (d >= 0) $display("FAIL midreset_decode got %0d bytes want %0d (idx %0d)", dec.size(), wq.size(), d);
      else pass_cnt++;
   endtask

   task automatic test_random();
      int d, n;
      for (int it = 0; it < 3; it++) begin
         n = $urandom_range(1, 5);
         wq.delete();
         for (int i = 0; i < n; i++) wq.push_back(8'($urandom_range(0, 255)));
         start_words();
         capture(n * PERIOD + 8);
         build_exp(n * PERIOD + 8);
         d = first_diff();
         total_cnt++;
         if (d >= 0) $display("FAIL random_wave it %0d cycle %0d got %b want %b", it, d, cap[d], expq[d]);
         else pass_cnt++;
         decode_line();
         d = dec_diff();
         total_cnt++;
         if (d >= 0) $display("FAIL random_decode it %0d got %0d bytes want %0d (idx %0d)", it, dec.size(), n, d);
         else pass_cnt++;
      end
   endtask

   initial begin
      bus.tx_en = 1'b0;
      test_reset();
      test_idle_disabled();
      test_single();
      test_back_to_back();
      test_empty();
      test_en_drop();
      test_reset_mid();
      test_random();
      total_cnt++;
      if (underflow != 0) $display("FAIL underflow got %0d pops on empty want 0", underflow);
      else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
